// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver (MSB first) with a one-entry valid/ready holding register.
// Optional UART_RX_SYNC_EN adds a 2-flop input synchroniser on rx.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            rx_s;
    logic            deliver;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;

    // Reset to the idle level so a reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    assign rx_s = sync[1];
`else
    assign rx_s = rx;
`endif

    assign deliver = (state == STOP) && (clk_cnt == LAST) && rx_s;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        clk_cnt <= '0;
                        // A one-clock bit has no midpoint to wait for.
                        if (HALF == '0) begin
                            state   <= DATA;
                            bit_cnt <= 3'd7;
                        end else begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    if (clk_cnt == HALF) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= 3'd7;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {shreg[6:0], rx_s};
                        if (bit_cnt == 3'd0) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A pop in the same cycle frees the slot for the arriving byte.
            if (deliver) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
